// File: rtl/serial_pattern_detector_if.sv
// Serial bit/command bus between the traffic-controller input path and the pattern detector.
// The detector uses the slave view. A driver (the control side) uses the master view.
interface serial_pattern_detector_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             bit_valid;
    logic             bit_in;
    logic             overlap_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             count_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output bit_valid, bit_in, overlap_en, pat_load, pat_in, count_clr,
        input  match, match_count, armed
    );

    modport slave (
        input  bit_valid, bit_in, overlap_en, pat_load, pat_in, count_clr,
        output match, match_count, armed
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Parametrised serial pattern detector with a runtime-loadable pattern.
// Supports overlapping and non-overlapping detection and a saturating match counter.
module serial_pattern_detector #(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 3'b101,
    parameter int               CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_pattern_detector_if.slave  bus
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] ARM_TH = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } fill_state_t;

    fill_state_t       state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              match_q;

    logic [PAT_W-1:0]  cand;
    logic              accept;
    logic              hit;

    // The candidate word completes when one bit short of a full history plus the incoming bit.
    assign cand   = {hist_q[PAT_W-2:0], bus.bit_in};
    assign accept = bus.bit_valid && !bus.pat_load;
    assign hit    = accept && (fill_q >= ARM_TH) && (cand == pattern_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            fill_q    <= '0;
            hist_q    <= '0;
            pattern_q <= DEFAULT_PAT;
            count_q   <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            match_q   <= hit;
        end
    end

    // A pattern load wipes the history so a stale partial word can never match the new pattern.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        state_d   = state_q;

        if (bus.pat_load) begin
            pattern_d = bus.pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.bit_valid) begin
            hist_d = cand;
            if (hit && !bus.overlap_en) begin
                fill_d = '0;
            end else if (fill_q < FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FULL) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

    // A clear that coincides with a hit keeps that hit, so the count restarts at one.
    always_comb begin
        count_d = count_q;
        if (bus.count_clr) begin
            count_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.armed       = (state_q == ARMED);

    assert property (@(posedge clk) disable iff (!rst_n) fill_q <= FULL);
    assert property (@(posedge clk) disable iff (!rst_n) (state_q == ARMED) == (fill_q == FULL));

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: three instances (3-bit, 8-bit, 2-bit/2-bit counter)
// share one stimulus stream; each test resets them all and checks the instance it targets.
module tb_serial_pattern_detector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_valid = 1'b0;
    logic        v_bit = 1'b0;
    logic        v_ovl = 1'b0;
    logic        v_load = 1'b0;
    logic        v_clr = 1'b0;
    logic [15:0] v_pat = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_detector_if #(.PAT_W(3), .CNT_W(8)) if3 ();
    serial_pattern_detector_if #(.PAT_W(8), .CNT_W(8)) if8 ();
    serial_pattern_detector_if #(.PAT_W(2), .CNT_W(2)) if2 ();

    assign if3.bit_valid = v_valid;
    assign if3.bit_in = v_bit;
    assign if3.overlap_en = v_ovl;
    assign if3.pat_load = v_load;
    assign if3.count_clr = v_clr;
    assign if3.pat_in = v_pat[2:0];
    assign if8.bit_valid = v_valid;
    assign if8.bit_in = v_bit;
    assign if8.overlap_en = v_ovl;
    assign if8.pat_load = v_load;
    assign if8.count_clr = v_clr;
    assign if8.pat_in = v_pat[7:0];
    assign if2.bit_valid = v_valid;
    assign if2.bit_in = v_bit;
    assign if2.overlap_en = v_ovl;
    assign if2.pat_load = v_load;
    assign if2.count_clr = v_clr;
    assign if2.pat_in = v_pat[1:0];

    serial_pattern_detector #(.PAT_W(3), .DEFAULT_PAT(3'b101), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );
    serial_pattern_detector #(.PAT_W(8), .DEFAULT_PAT(8'h00), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );
    serial_pattern_detector #(.PAT_W(2), .DEFAULT_PAT(2'b11), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        bitv;
        logic        ovl;
        logic        load;
        logic        clr;
        logic [15:0] pat;
        logic        exp_match;
        logic [15:0] exp_count;
        logic        exp_armed;
    } vec_t;

    vec_t tbl[$];

    task automatic addRow(input string name, input logic valid, input logic bitv, input logic ovl,
                          input logic load, input logic clr, input logic [15:0] pat,
                          input logic em, input logic [15:0] ec, input logic ea);
        vec_t v;
        v.name = name; v.valid = valid; v.bitv = bitv; v.ovl = ovl; v.load = load; v.clr = clr;
        v.pat = pat; v.exp_match = em; v.exp_count = ec; v.exp_armed = ea;
        tbl.push_back(v);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit after the next edge.
    task automatic applyStimulus(input logic valid, input logic bitv, input logic ovl,
                                 input logic load, input logic clr, input logic [15:0] pat);
        v_valid = valid; v_bit = bitv; v_ovl = ovl; v_load = load; v_clr = clr; v_pat = pat;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic am, input logic [15:0] ac,
                               input logic aa, input logic em, input logic [15:0] ec,
                               input logic ea);
        checks++;
        if ({am, ac, aa} !== {em, ec, ea}) begin
            errors++;
            $display("[TB] FAIL %s: got match=%0b count=%0d armed=%0b, need match=%0b count=%0d armed=%0b",
                     name, am, ac, aa, em, ec, ea);
        end
    endtask

    task automatic check3(input string name, input logic em, input logic [15:0] ec, input logic ea);
        checkOutput(name, if3.match, 16'(if3.match_count), if3.armed, em, ec, ea);
    endtask

    task automatic check8(input string name, input logic em, input logic [15:0] ec, input logic ea);
        checkOutput(name, if8.match, 16'(if8.match_count), if8.armed, em, ec, ea);
    endtask

    task automatic check2(input string name, input logic em, input logic [15:0] ec, input logic ea);
        checkOutput(name, if2.match, 16'(if2.match_count), if2.armed, em, ec, ea);
    endtask

    task automatic doReset();
        v_valid = 0; v_bit = 0; v_ovl = 0; v_load = 0; v_clr = 0; v_pat = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1 overlap, load/clear restart, T2 non-overlap, overlap_en changed on the hit cycle.
        addRow("t1_b1", 1, 1, 1, 0, 0, 16'h0, 0, 0, 0);
        addRow("t1_b2", 1, 0, 1, 0, 0, 16'h0, 0, 0, 0);
        addRow("t1_b3", 1, 1, 1, 0, 0, 16'h0, 1, 1, 1);
        addRow("t1_b4", 1, 0, 1, 0, 0, 16'h0, 0, 1, 1);
        addRow("t1_b5", 1, 1, 1, 0, 0, 16'h0, 1, 2, 1);
        addRow("t1_b6", 1, 0, 1, 0, 0, 16'h0, 0, 2, 1);
        addRow("load_masks_hit", 1, 1, 1, 1, 1, 16'h5, 0, 0, 0);
        addRow("t2_b1", 1, 1, 0, 0, 0, 16'h0, 0, 0, 0);
        addRow("t2_b2", 1, 0, 0, 0, 0, 16'h0, 0, 0, 0);
        addRow("t2_b3", 1, 1, 0, 0, 0, 16'h0, 1, 1, 0);
        addRow("t2_b4", 1, 0, 0, 0, 0, 16'h0, 0, 1, 0);
        addRow("t2_b5", 1, 1, 0, 0, 0, 16'h0, 0, 1, 0);
        addRow("t2_idle", 0, 1, 0, 0, 0, 16'h0, 0, 1, 0);
        addRow("ovl_b1", 1, 0, 1, 0, 0, 16'h0, 0, 1, 1);
        addRow("ovl_switch_hit", 1, 1, 0, 0, 0, 16'h0, 1, 2, 0);
        addRow("clr_alone", 0, 0, 0, 0, 1, 16'h0, 0, 0, 0);

        doReset();
        check3("reset3", 0, 0, 0);
        check8("reset8", 0, 0, 0);
        check2("reset2", 0, 0, 0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].valid, tbl[i].bitv, tbl[i].ovl, tbl[i].load, tbl[i].clr, tbl[i].pat);
            check3(tbl[i].name, tbl[i].exp_match, tbl[i].exp_count, tbl[i].exp_armed);
        end

        // T3: gaps of three invalid cycles with a tempting bit_in=1 on the wire.
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check3("t3_b1", 0, 0, 0);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(0, 1, 1, 0, 0, 16'h0);
            check3("t3_gap1", 0, 0, 0);
        end
        applyStimulus(1, 0, 1, 0, 0, 16'h0);
        check3("t3_b2", 0, 0, 0);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(0, 1, 1, 0, 0, 16'h0);
            check3("t3_gap2", 0, 0, 0);
        end
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check3("t3_b3", 1, 1, 1);
        applyStimulus(0, 1, 1, 0, 0, 16'h0);
        check3("t3_pulse_end", 0, 1, 1);

        // T4: 8-bit pattern A5; the bit offered with pat_load must be dropped.
        doReset();
        applyStimulus(1, 1, 1, 1, 0, 16'h00A5);
        check8("t4_load", 0, 0, 0);
        begin
            logic [7:0] word;
            word = 8'hA5;
            for (int b = 7; b >= 0; b--) begin
                applyStimulus(1, word[b], 1, 0, 0, 16'h0);
                if (b == 0) check8("t4_b8", 1, 1, 1);
                else check8("t4_fill", 0, 0, 0);
            end
        end
        applyStimulus(0, 0, 1, 0, 0, 16'h0);
        check8("t4_after", 0, 1, 1);

        // T5: 2-bit pattern 11 with a 2-bit counter saturating at 3.
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_b1", 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_b2", 1, 1, 1);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_b3", 1, 2, 1);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_b4", 1, 3, 1);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_sat1", 1, 3, 1);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check2("t5_sat2", 1, 3, 1);
        applyStimulus(1, 1, 1, 0, 1, 16'h0);
        check2("t5_clr_hit", 1, 1, 1);
        applyStimulus(1, 0, 1, 0, 0, 16'h0);
        check2("t5_nohit", 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 1, 16'h0);
        check2("t5_clr", 0, 0, 1);

        // T6: asynchronous reset in the middle of a cycle discards the trailing "10".
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        applyStimulus(1, 0, 1, 0, 0, 16'h0);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check3("t6_pre_hit", 1, 1, 1);
        applyStimulus(1, 0, 1, 0, 0, 16'h0);
        check3("t6_pre_armed", 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check3("t6_async", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check3("t6_restart", 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 16'h0);
        check3("t6_b2", 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        check3("t6_b3", 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
